i2s_dac_tx: RTL and testbench
=============================

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 SHALL have parameter fxp_size, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter slot_bits, default 32, BCLK periods per channel slot; legal range slot_bits >= fxp_size.
REQ-003 SHALL have parameter bclk_div, default 4, clk cycles per BCLK period; legal values are even and >= 2.
REQ-004 SHALL have ports clk (input, 1): single system clock, all logic on rising edge.
REQ-005 SHALL have port rst (input, 1): reset, synchronous, active-low.
REQ-006 SHALL have port i_valid (input, 1): i_sample is valid this cycle.
REQ-007 SHALL have port i_sample (input, fxp_size): processed mono sample from the effects pipeline.
REQ-008 SHALL have port o_ready (output, 1): buffer can accept a sample this cycle.
REQ-009 SHALL have ports o_bclk, o_lrclk, o_sdata (output, 1 each): I2S bit clock, word select (0 = left), serial data to DAC.
REQ-010 SHALL have ports o_underrun, o_overflow (output, 1 each): single-cycle error pulses.

Function
REQ-011 SHALL buffer input in a 2-entry FIFO; push when i_valid=1 and (count<2 or pop in same cycle).
REQ-012 SHALL drive o_ready = (count<2), derived from the registered count.
REQ-013 SHALL drop a sample with i_valid=1, count=2 and no pop in the same cycle, and pulse o_overflow for 1 cycle.
REQ-014 SHALL run div_cnt 0..bclk_div-1, wrapping; o_bclk = 0 for div_cnt < bclk_div/2, else 1, registered.
REQ-015 SHALL define the falling-edge event (FE) as the cycle div_cnt wraps from bclk_div-1 to 0.
REQ-016 SHALL run bit_cnt 0..2*slot_bits-1, advancing only on FE and wrapping to 0; FE with new bit_cnt=0 is frame start (FS).
REQ-017 SHALL drive o_lrclk = 1 when bit_cnt is in [slot_bits-1, 2*slot_bits-2], else 0, giving the standard I2S one-BCLK delay.
REQ-018 SHALL, at FS, pop the FIFO head into the frame register and last_sample if count>0.
REQ-019 SHALL, at FS with count=0, reuse last_sample and pulse o_underrun for 1 cycle.
REQ-020 SHALL transmit the frame register MSB first on both channels (mono duplicate): bit_cnt k in [0, fxp_size-1] carries bit fxp_size-1-k; bit_cnt slot_bits+k carries the same bit.
REQ-021 SHALL drive o_sdata = 0 for bit_cnt in [fxp_size, slot_bits-1] and [slot_bits+fxp_size, 2*slot_bits-1].
REQ-022 SHALL update o_sdata and o_lrclk only on FE, registered in the same cycle o_bclk goes low, so data is stable at the next BCLK rising edge.
REQ-023 SHALL accept simultaneous push and pop when count=2: count stays 2, no overflow.
REQ-024 SHALL accept a push into an empty FIFO coinciding with FS, but SHALL NOT pop that sample at that FS (underrun fires); it is sent at the next FS.

Reset
REQ-025 SHALL, while rst=0, set div_cnt=0, bit_cnt=2*slot_bits-1, FIFO empty, frame register and last_sample 0, o_bclk=0, o_lrclk=0, o_sdata=0, o_underrun=0, o_overflow=0, o_ready=1.
REQ-026 SHALL, with rst asserted mid-frame, abort the frame, discard buffered samples, and return to the REQ-025 state the next cycle.
REQ-027 SHALL make the first FS occur bclk_div cycles after rst deasserts.

Verification
REQ-028 Single sample: defaults, push 16'hA5C3 before the first FS -> left and right slots each carry A5C3 MSB first then 16 zeros; o_underrun=0 for that frame.
REQ-029 Underrun: no push after the REQ-028 frame -> next FS repeats A5C3, o_underrun pulses exactly 1 cycle at FS.
REQ-030 Overflow: push 3 samples on consecutive cycles away from FS -> o_ready=0 after 2, third dropped, o_overflow pulses once; next two frames send samples 1 and 2.
REQ-031 Timing: defaults -> o_bclk period 4 clk; o_lrclk period 256 clk; o_lrclk toggles 1 BCLK before each slot's MSB; o_sdata changes only when o_bclk falls.
REQ-032 Mid-frame reset: rst=0 at bit_cnt=20 with count=1 -> outputs 0, o_ready=1 next cycle; first post-reset frame sends 0 with o_underrun pulse.
REQ-033 Full push/pop: count=2 with a push at FS -> no overflow, count stays 2, order preserved.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for a mono sample stream: 2-entry input FIFO, BCLK/LRCLK generation,
// and MSB-first serialisation of each sample into both left and right slots.
module i2s_dac_tx #(
   parameter int fxp_size  = 16,
   parameter int slot_bits = 32,
   parameter int bclk_div  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic [fxp_size-1:0] i_sample,
   output logic                o_ready,
   output logic                o_bclk,
   output logic                o_lrclk,
   output logic                o_sdata,
   output logic                o_underrun,
   output logic                o_overflow
);

   localparam int DW = $clog2(bclk_div);
   localparam int CW = $clog2(2 * slot_bits);

   localparam logic [DW-1:0]       DIV_LAST = DW'(bclk_div - 1);
   localparam logic [DW-1:0]       DIV_HALF = DW'(bclk_div / 2);
   localparam logic [CW-1:0]       BIT_LAST = CW'(2 * slot_bits - 1);
   localparam logic [CW-1:0]       LR_FIRST = CW'(slot_bits - 1);
   localparam logic [CW-1:0]       LR_LAST  = CW'(2 * slot_bits - 2);
   localparam logic [CW-1:0]       L_LAST   = CW'(fxp_size - 1);
   localparam logic [CW-1:0]       R_FIRST  = CW'(slot_bits);
   localparam logic [CW-1:0]       R_LAST   = CW'(slot_bits + fxp_size - 1);
   localparam logic [fxp_size-1:0] MSB_MASK = {1'b1, {(fxp_size - 1){1'b0}}};

   logic [DW-1:0]       div_cnt_q, div_cnt_d;
   logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [1:0]          count_q, count_d;
   logic [fxp_size-1:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d;
   logic [fxp_size-1:0] frame_q, frame_d, last_q, last_d;
   logic                bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
   logic                und_q, und_d, ovf_q, ovf_d;
   logic                fe, fs, pop, push;
   logic [CW-1:0]       shamt;

   always_comb begin
      fe        = (div_cnt_q == DIV_LAST);
      div_cnt_d = fe ? '0 : div_cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      if (fe) begin
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      end
      fs    = fe && (bit_cnt_q == BIT_LAST);
      pop   = fs && (count_q != 2'd0);
      push  = i_valid && ((count_q < 2'd2) || pop);
      ovf_d = i_valid && (count_q == 2'd2) && !pop;
      und_d = fs && (count_q == 2'd0);

      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      // Head lives in fifo0; the write slot is the occupancy left after this cycle's pop.
      fifo0_d = fifo0_q;
      fifo1_d = fifo1_q;
      if (pop) begin
         fifo0_d = fifo1_q;
      end
      if (push) begin
         if (((count_q == 2'd2) && pop) || ((count_q == 2'd1) && !pop)) begin
            fifo1_d = i_sample;
         end else begin
            fifo0_d = i_sample;
         end
      end

      frame_d = frame_q;
      last_d  = last_q;
      if (pop) begin
         frame_d = fifo0_q;
         last_d  = fifo0_q;
      end else if (fs) begin
         frame_d = last_q;
      end

      bclk_d  = (div_cnt_d >= DIV_HALF);
      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      shamt   = '0;
      // Serial bit is taken from the post-update frame so the MSB goes out at frame start.
      if (fe) begin
         lrclk_d = (bit_cnt_d >= LR_FIRST) && (bit_cnt_d <= LR_LAST);
         if (bit_cnt_d <= L_LAST) begin
            shamt   = bit_cnt_d;
            sdata_d = |(frame_d & (MSB_MASK >> shamt));
         end else if ((bit_cnt_d >= R_FIRST) && (bit_cnt_d <= R_LAST)) begin
            shamt   = bit_cnt_d - R_FIRST;
            sdata_d = |(frame_d & (MSB_MASK >> shamt));
         end else begin
            sdata_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt_q <= '0;
         bit_cnt_q <= BIT_LAST;
         count_q   <= '0;
         fifo0_q   <= '0;
         fifo1_q   <= '0;
         frame_q   <= '0;
         last_q    <= '0;
         bclk_q    <= 1'b0;
         lrclk_q   <= 1'b0;
         sdata_q   <= 1'b0;
         und_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         count_q   <= count_d;
         fifo0_q   <= fifo0_d;
         fifo1_q   <= fifo1_d;
         frame_q   <= frame_d;
         last_q    <= last_d;
         bclk_q    <= bclk_d;
         lrclk_q   <= lrclk_d;
         sdata_q   <= sdata_d;
         und_q     <= und_d;
         ovf_q     <= ovf_d;
      end
   end

   assign o_ready    = (count_q < 2'd2);
   assign o_bclk     = bclk_q;
   assign o_lrclk    = lrclk_q;
   assign o_sdata    = sdata_q;
   assign o_underrun = und_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: directed push/frame tables plus a randomized run
// checked every cycle against a queue-and-arithmetic reference model.
module tb_i2s_dac_tx;

   localparam int F  = 16;
   localparam int S  = 32;
   localparam int D  = 4;
   localparam int FR = 2 * S * D;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         i_valid = 1'b0;
   logic [F-1:0] i_sample = '0;
   logic         o_ready, o_bclk, o_lrclk, o_sdata, o_underrun, o_overflow;

   int pass_cnt = 0;
   int total_cnt = 0;
   int ecnt = 0;

   logic [F-1:0] mq[$];
   logic [F-1:0] m_word = '0;
   logic [F-1:0] m_last = '0;
   logic         m_und = 1'b0;
   logic         m_ovf = 1'b0;
   int           m_pre, m_b;
   logic         m_fs, m_pop;
   logic [5:0]   m_ex;

   typedef struct { int at; logic [F-1:0] smp; } push_t;
   typedef struct { int m; logic [F-1:0] word; logic und; } frame_t;
   push_t  ptab[$];
   frame_t ftab[$];
   int     rates[6] = '{0, 3, 40, 1, 100, 2};

   i2s_dac_tx #(.fxp_size(F), .slot_bits(S), .bclk_div(D)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_sample(i_sample),
      .o_ready(o_ready), .o_bclk(o_bclk), .o_lrclk(o_lrclk), .o_sdata(o_sdata),
      .o_underrun(o_underrun), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic exp_sdata(input logic [F-1:0] w, input int b);
      logic [F-1:0] sh;
      int k;
      if (b < F) k = b;
      else if (b >= S && b < S + F) k = b - S;
      else return 1'b0;
      sh = w >> (F - 1 - k);
      return sh[0];
   endfunction

   // Reference model: edges counted since reset release give all timing by arithmetic.
   always @(posedge clk) begin
      if (!rst) begin
         ecnt = 0;
         mq.delete();
         m_word = '0;
         m_last = '0;
         m_und  = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         ecnt++;
         m_fs  = (ecnt >= D) && ((ecnt - D) % FR == 0);
         m_pre = mq.size();
         m_pop = m_fs && (m_pre > 0);
         m_und = m_fs && !m_pop;
         if (m_pop) begin
            m_word = mq.pop_front();
            m_last = m_word;
         end else if (m_fs) begin
            m_word = m_last;
         end
         m_ovf = i_valid && (m_pre == 2) && !m_pop;
         if (i_valid && ((m_pre < 2) || m_pop)) mq.push_back(i_sample);
      end
      m_b  = (ecnt / D + 2 * S - 1) % (2 * S);
      m_ex = {mq.size() < 2, (ecnt % D) >= D / 2, (m_b >= S - 1) && (m_b <= 2 * S - 2),
              exp_sdata(m_word, m_b), m_und, m_ovf};
      #1;
      chk("outputs", {58'd0, o_ready, o_bclk, o_lrclk, o_sdata, o_underrun, o_overflow},
          {58'd0, m_ex});
   end

   task automatic wait_ecnt(input string tag, input int target);
      int g = 0;
      while (ecnt != target && g < 3000) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "_sync"}, 64'(ecnt), 64'(target));
   endtask

   task automatic check_frame(input string tag, input int m, input logic [F-1:0] w, input logic u);
      int fs = D + m * FR;
      logic [2*S-1:0] got = '0;
      wait_ecnt(tag, fs);
      chk({tag, "_und"}, 64'(o_underrun), 64'(u));
      wait_ecnt(tag, fs + 1);
      chk({tag, "_und_end"}, 64'(o_underrun), 64'd0);
      for (int j = 0; j < 2 * S; j++) begin
         wait_ecnt(tag, fs + D / 2 + j * D);
         got[2*S-1-j] = o_sdata;
      end
      chk({tag, "_data"}, 64'(got), {w, {(S - F){1'b0}}, w, {(S - F){1'b0}}});
   endtask

   initial begin
      ptab.push_back('{0,    16'hA5C3});
      ptab.push_back('{300,  16'h1111});
      ptab.push_back('{301,  16'h2222});
      ptab.push_back('{302,  16'h3333});
      ptab.push_back('{800,  16'h4444});
      ptab.push_back('{801,  16'h5555});
      ptab.push_back('{1027, 16'h6666});
      ptab.push_back('{2051, 16'h7777});
      ptab.push_back('{2600, 16'h8888});
      ftab.push_back('{0, 16'hA5C3, 1'b0});
      ftab.push_back('{1, 16'hA5C3, 1'b1});
      ftab.push_back('{2, 16'h1111, 1'b0});
      ftab.push_back('{3, 16'h2222, 1'b0});
      ftab.push_back('{4, 16'h4444, 1'b0});
      ftab.push_back('{5, 16'h5555, 1'b0});
      ftab.push_back('{6, 16'h6666, 1'b0});
      ftab.push_back('{7, 16'h6666, 1'b1});
      ftab.push_back('{8, 16'h6666, 1'b1});
      ftab.push_back('{9, 16'h7777, 1'b0});

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", {58'd0, o_ready, o_bclk, o_lrclk, o_sdata, o_underrun, o_overflow},
          64'b100000);
      rst = 1'b1;

      fork
         begin
            int g = 0;
            while (ecnt < 2645 && g < 4000) begin
               i_valid = 1'b0;
               foreach (ptab[i]) begin
                  if (ptab[i].at == ecnt) begin
                     i_valid  = 1'b1;
                     i_sample = ptab[i].smp;
                  end
               end
               if (ecnt == 301)  chk("ready_one",  64'(o_ready), 64'd1);
               if (ecnt == 302)  chk("ready_full", 64'(o_ready), 64'd0);
               if (ecnt == 303)  chk("ovf_pulse",  64'(o_overflow), 64'd1);
               if (ecnt == 304)  chk("ovf_end",    64'(o_overflow), 64'd0);
               if (ecnt == 1028) chk("fullpp",     64'({o_ready, o_overflow}), 64'd0);
               @(negedge clk);
               g++;
            end
            i_valid = 1'b0;
            rst     = 1'b0;
         end
         begin
            foreach (ftab[i]) check_frame($sformatf("frame%0d", ftab[i].m), ftab[i].m,
                                          ftab[i].word, ftab[i].und);
         end
      join

      @(negedge clk);
      chk("mid_rst", {58'd0, o_ready, o_bclk, o_lrclk, o_sdata, o_underrun, o_overflow},
          64'b100000);
      @(negedge clk);
      rst = 1'b1;
      check_frame("post_rst", 0, '0, 1'b1);

      for (int n = 0; n < 3000; n++) begin
         i_valid  = ($urandom_range(0, 99) < rates[n / 500]);
         i_sample = F'($urandom);
         rst      = !(n >= 1500 && n < 1502);
         @(negedge clk);
      end
      i_valid = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
